// File: rtl/ui_control_bank.sv
// Bank of NUM_CTRL mouse-adjustable controls selected by pointer zone, stepped by left/right buttons.
// Optional auto-repeat while a button is held is enabled by defining UI_AUTOREPEAT_EN.
module ui_control_bank #(
   parameter int NUM_CTRL    = 4,
   parameter int CTRL_W      = 12,
   parameter int ZONE_W      = 256,
   parameter int RESET_VAL   = 128,
   parameter int COARSE_STEP = 16,
   parameter int HOLDOFF     = 100000,
   parameter int REPEAT      = 20000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         left_mouse,
   input  logic                         right_mouse,
   input  logic                         middle_mouse,
   input  logic [11:0]                  xpos,
   input  logic [11:0]                  ypos,
   output logic [NUM_CTRL*CTRL_W-1:0]   ctrl_val,
   output logic [$clog2(NUM_CTRL)-1:0]  active_idx,
   output logic                         step_pulse,
   output logic                         busy
);
   localparam int IDX_W = $clog2(NUM_CTRL);
   localparam logic [CTRL_W-1:0] MAXV = '1;

   typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

   state_t                             state_q, state_d;
   logic [NUM_CTRL-1:0][CTRL_W-1:0]    val_q, val_d;
   logic [IDX_W-1:0]                   idx_q, idx_d;
   logic                               dir_q, dir_d;
   logic                               pulse_q, pulse_d;
   logic                               wait_q, wait_d;

   logic                               press, zone_ok, keep, do_step, step_dir;
   logic [IDX_W-1:0]                   zone, step_idx;
   logic [CTRL_W-1:0]                  step_amt, cur, nxt;
   logic                               unused_ypos;

`ifdef UI_AUTOREPEAT_EN
   localparam int CNT_MAX = (HOLDOFF > REPEAT) ? HOLDOFF : REPEAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d, lim;
   assign lim = (state_q == HOLD) ? CNT_W'(HOLDOFF - 1) : CNT_W'(REPEAT - 1);
`endif

   assign unused_ypos = ^ypos;
   assign press   = left_mouse ^ right_mouse;
   assign zone_ok = 32'(xpos) < 32'(NUM_CTRL * ZONE_W);
   assign zone    = IDX_W'(32'(xpos) / ZONE_W);
   assign keep    = dir_q ? (right_mouse & ~left_mouse) : (left_mouse & ~right_mouse);

   // Saturating step datapath: IDLE steps the pointed zone, HOLD/RPT the latched one.
   assign step_idx = (state_q == IDLE) ? zone : idx_q;
   assign step_dir = (state_q == IDLE) ? right_mouse : dir_q;
   assign step_amt = middle_mouse ? CTRL_W'(COARSE_STEP) : CTRL_W'(1);
   assign cur      = val_q[step_idx];
   assign nxt      = step_dir ? (((MAXV - cur) < step_amt) ? MAXV : cur + step_amt)
                              : ((cur < step_amt) ? '0 : cur - step_amt);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dir_d   = dir_q;
      wait_d  = wait_q;
      do_step = 1'b0;
`ifdef UI_AUTOREPEAT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            // wait_q blocks any press until both buttons have been seen released
            if (!(left_mouse | right_mouse)) begin
               wait_d = 1'b0;
            end else if (!wait_q) begin
               if (press && zone_ok) begin
                  do_step = 1'b1;
                  idx_d   = zone;
                  dir_d   = right_mouse;
                  state_d = HOLD;
`ifdef UI_AUTOREPEAT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  wait_d = 1'b1;
               end
            end
         end
         default: begin
            if (!keep) begin
               state_d = IDLE;
               wait_d  = left_mouse | right_mouse;
`ifdef UI_AUTOREPEAT_EN
               cnt_d   = '0;
`endif
            end else begin
`ifdef UI_AUTOREPEAT_EN
               if (cnt_q == lim) begin
                  do_step = 1'b1;
                  cnt_d   = '0;
                  state_d = RPT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
         end
      endcase
      val_d = val_q;
      if (do_step) val_d[step_idx] = nxt;
      pulse_d = do_step;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         val_q   <= {NUM_CTRL{CTRL_W'(RESET_VAL)}};
         idx_q   <= '0;
         dir_q   <= 1'b0;
         pulse_q <= 1'b0;
         wait_q  <= 1'b1;
`ifdef UI_AUTOREPEAT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
         pulse_q <= pulse_d;
         wait_q  <= wait_d;
`ifdef UI_AUTOREPEAT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign ctrl_val   = val_q;
   assign active_idx = idx_q;
   assign step_pulse = pulse_q;
   assign busy       = (state_q != IDLE);
endmodule

// File: doc/ui_control_bank.md
UI_CONTROL_BANK -- requirements
Module: ui_control_bank

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- NUM_CTRL, 4, number of independent mouse-adjustable controls.
- CTRL_W, 12, width of each control value.
- ZONE_W, 256, horizontal pixel width of each control zone.
- RESET_VAL, 128, reset value of every control.
- COARSE_STEP, 16, step size applied while middle_mouse is held.
- HOLDOFF, 100000, cycles from first step to first auto-repeat step.
- REPEAT, 20000, cycles between auto-repeat steps.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock.
- rst, in, 1, reset.
- left_mouse, in, 1, decrement button.
- right_mouse, in, 1, increment button.
- middle_mouse, in, 1, coarse-step modifier.
- xpos, in, 12, pointer x position.
- ypos, in, 12, pointer y position (unused by the control logic; reserved).
- ctrl_val, out, NUM_CTRL*CTRL_W, packed control values; control k occupies bits [k*CTRL_W +: CTRL_W].
- active_idx, out, $clog2(NUM_CTRL), index of the control latched on the last press.
- step_pulse, out, 1, one-cycle strobe on every applied step.
- busy, out, 1, high when the FSM is not in IDLE.
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The zone SHALL be xpos / ZONE_W, and a zone SHALL be valid only when xpos < NUM_CTRL*ZONE_W.
REQ-005 A press SHALL be exactly one of left_mouse and right_mouse high; both high or neither high SHALL be no press.
REQ-006 The FSM SHALL have three states:
- IDLE: on a press in a valid zone, latch the zone into active_idx, latch the button, apply one step, go to HOLD.
- HOLD: count holdoff cycles.
- RPT: count repeat cycles.
REQ-007 The step SHALL be +step for right_mouse and -step for left_mouse, with step = COARSE_STEP when middle_mouse is high at the step cycle and 1 otherwise.
REQ-008 Arithmetic SHALL saturate at 0 and 2^CTRL_W-1, with no wrap-around; a step at the limit SHALL still pulse step_pulse.
REQ-009 A step SHALL update ctrl_val and assert step_pulse at the first clk edge after the sampling edge, giving a latency of one cycle.
REQ-010 In HOLD or RPT, if the latched button is released, or the other button is also pressed, the FSM SHALL return to IDLE on the next edge without stepping.
REQ-011 While a button is held, steps SHALL apply only to the latched control, even if the pointer leaves the zone or leaves the valid area.
REQ-012 Only the latched control SHALL change; all other controls SHALL hold their values.
REQ-013 A press in an invalid zone SHALL leave the FSM in IDLE, and it SHALL NOT start a step when the pointer later moves into a valid zone while the button is still held (button must be released first).
REQ-014 busy SHALL be high in HOLD and RPT, and low in IDLE.

Reset
REQ-015 On rst high, the block SHALL immediately take these values:
- every control equal to RESET_VAL;
- active_idx = 0;
- step_pulse = 0;
- FSM in IDLE;
- counters = 0.
REQ-016 A reset asserted mid-hold SHALL abort the sequence, and no step SHALL occur after reset is released until a new press arrives.

Configuration
REQ-017 With macro UI_AUTOREPEAT_EN defined, HOLD SHALL step after HOLDOFF cycles and enter RPT, and RPT SHALL step every REPEAT cycles while the button is held.
REQ-018 Without UI_AUTOREPEAT_EN, the block SHALL give exactly one step per press, HOLD SHALL wait for release, and RPT SHALL be unreachable.

Verification (simulation with HOLDOFF=8, REPEAT=4, default widths)
REQ-019 Single step: after reset, right_mouse pulsed for 1 cycle at xpos=300 -> control1 = 129, active_idx=1, one step_pulse, busy low 2 cycles later.
REQ-020 Coarse step and saturation: control0 preset near 0 by 8 single-cycle left_mouse presses at xpos=10 with middle_mouse high -> control0 = 0 after the 8th press, step_pulse on each press; a further coarse left press leaves it at 0.
REQ-021 Auto-repeat (macro defined): right_mouse held 21 cycles at xpos=600 -> steps at cycles 1, 9, 13, 17, 21, giving control2 = 133.
REQ-022 Macro undefined, same stimulus as REQ-021 -> control2 = 129 and a single step_pulse.
REQ-023 Edge cases:
- both buttons pressed in IDLE -> no change;
- press at xpos=1100 -> no change, busy stays 0;
- pointer dragged from 300 to 900 while held -> only control1 changes;
- rst asserted mid-hold -> all controls = 128, busy=0.
